// File: rtl/clock_time_setter_if.sv
// Key-press inputs and time/blink outputs of the clock time setter.
// The master side drives the key pulses; the slave side is the setter itself.
interface clock_time_setter_if;
    logic       tick_1hz;
    logic       press_mode;
    logic       press_inc;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] set_mode;
    logic       blank_hour;
    logic       blank_min;

    modport master (
        output tick_1hz, press_mode, press_inc,
        input  hour, minute, second, set_mode, blank_hour, blank_min
    );

    modport slave (
        input  tick_1hz, press_mode, press_inc,
        output hour, minute, second, set_mode, blank_hour, blank_min
    );
endinterface

// File: rtl/clock_time_setter.sv
// Time-of-day registers with a RUN / SET_HOUR / SET_MIN edit FSM, an edit
// timeout back to RUN, and a blink phase for the field being edited.
module clock_time_setter #(
    parameter int HOUR_MAX   = 23,
    parameter int MIN_MAX    = 59,
    parameter int SEC_MAX    = 59,
    parameter int BLINK_HALF = 250,
    parameter int TIMEOUT    = 10000
) (
    input  logic                 clk,
    input  logic                 rst_N,
    clock_time_setter_if.slave   bus
);
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [1:0] S_RUN  = 2'b00;
    localparam logic [1:0] S_HOUR = 2'b01;
    localparam logic [1:0] S_MIN  = 2'b10;

    logic [1:0]      r_state, w_nxt_state;
    logic [4:0]      r_hour, w_hour;
    logic [5:0]      r_min, w_min, r_sec, w_sec;
    logic [TO_W-1:0] r_to_cnt, w_to_cnt;
    logic [BL_W-1:0] r_bl_cnt, w_bl_cnt;
    logic            r_phase, w_phase;
    logic            r_blank_hour, w_blank_hour, r_blank_min, w_blank_min;
    logic            w_press, w_edit, w_timeout, w_nxt_edit, w_entry;

    assign w_press   = bus.press_mode | bus.press_inc;
    assign w_edit    = (r_state == S_HOUR) || (r_state == S_MIN);
    assign w_timeout = w_edit && !w_press && (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) r_state <= S_RUN;
        else        r_state <= w_nxt_state;
    end

    // Mode always wins over inc; the encoding 11 falls back to RUN.
    always_comb begin
        w_nxt_state = S_RUN;
        case (r_state)
            S_RUN:   w_nxt_state = bus.press_mode ? S_HOUR : S_RUN;
            S_HOUR:  w_nxt_state = bus.press_mode ? S_MIN  : (w_timeout ? S_RUN : S_HOUR);
            S_MIN:   w_nxt_state = bus.press_mode ? S_RUN  : (w_timeout ? S_RUN : S_MIN);
            default: w_nxt_state = S_RUN;
        endcase
    end

    always_comb begin
        w_hour = r_hour;
        w_min  = r_min;
        w_sec  = r_sec;
        case (r_state)
            S_RUN: begin
                if (bus.tick_1hz) begin
                    if (r_sec == 6'(SEC_MAX)) begin
                        w_sec = '0;
                        if (r_min == 6'(MIN_MAX)) begin
                            w_min  = '0;
                            w_hour = (r_hour == 5'(HOUR_MAX)) ? 5'd0 : r_hour + 5'd1;
                        end else begin
                            w_min = r_min + 6'd1;
                        end
                    end else begin
                        w_sec = r_sec + 6'd1;
                    end
                end
            end
            S_HOUR: if (bus.press_inc && !bus.press_mode)
                        w_hour = (r_hour == 5'(HOUR_MAX)) ? 5'd0 : r_hour + 5'd1;
            S_MIN:  if (bus.press_inc && !bus.press_mode)
                        w_min = (r_min == 6'(MIN_MAX)) ? 6'd0 : r_min + 6'd1;
            default: ;
        endcase
        // Leaving edit (mode exit from SET_MIN or timeout) restarts the minute.
        if (w_edit && (w_nxt_state == S_RUN)) w_sec = '0;

        w_nxt_edit = (w_nxt_state == S_HOUR) || (w_nxt_state == S_MIN);
        w_entry    = w_nxt_edit && (w_nxt_state != r_state);

        w_to_cnt = (!w_nxt_edit || w_entry || w_press) ? '0 : r_to_cnt + TO_W'(1);

        w_bl_cnt = r_bl_cnt;
        w_phase  = r_phase;
        if (!w_nxt_edit || w_entry || bus.press_inc) begin
            w_bl_cnt = '0;
            w_phase  = 1'b0;
        end else if (r_bl_cnt == BL_W'(BLINK_HALF - 1)) begin
            w_bl_cnt = '0;
            w_phase  = ~r_phase;
        end else begin
            w_bl_cnt = r_bl_cnt + BL_W'(1);
        end

        w_blank_hour = (w_nxt_state == S_HOUR) && w_phase;
        w_blank_min  = (w_nxt_state == S_MIN)  && w_phase;
    end

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            r_hour       <= '0;
            r_min        <= '0;
            r_sec        <= '0;
            r_to_cnt     <= '0;
            r_bl_cnt     <= '0;
            r_phase      <= 1'b0;
            r_blank_hour <= 1'b0;
            r_blank_min  <= 1'b0;
        end else begin
            r_hour       <= w_hour;
            r_min        <= w_min;
            r_sec        <= w_sec;
            r_to_cnt     <= w_to_cnt;
            r_bl_cnt     <= w_bl_cnt;
            r_phase      <= w_phase;
            r_blank_hour <= w_blank_hour;
            r_blank_min  <= w_blank_min;
        end
    end

    assign bus.hour       = r_hour;
    assign bus.minute     = r_min;
    assign bus.second     = r_sec;
    assign bus.set_mode   = r_state;
    assign bus.blank_hour = r_blank_hour;
    assign bus.blank_min  = r_blank_min;
endmodule

// File: tb/tb_clock_time_setter.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares against the DUT outputs.
module tb_clock_time_setter;
    localparam int TIMEOUT    = 10000;
    localparam int BLINK_HALF = 250;

    logic clk   = 1'b0;
    logic rst_N = 1'b0;

    clock_time_setter_if bus();

    clock_time_setter #(
        .HOUR_MAX(23), .MIN_MAX(59), .SEC_MAX(59),
        .BLINK_HALF(BLINK_HALF), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_N(rst_N),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] md;
        logic       bh;
        logic       bm;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // One clock: inputs held across the next rising edge, then released.
    task automatic cyc(input logic t, input logic mo, input logic in);
        bus.tick_1hz   = t;
        bus.press_mode = mo;
        bus.press_inc  = in;
        @(posedge clk);
        #1;
        bus.tick_1hz   = 1'b0;
        bus.press_mode = 1'b0;
        bus.press_inc  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_st(input string nm, input logic [4:0] h, input logic [5:0] m,
                             input logic [5:0] s, input logic [1:0] md,
                             input logic bh, input logic bm);
        exp_t e;
        e.name = nm; e.h = h; e.m = m; e.s = s; e.md = md; e.bh = bh; e.bm = bm;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            n_vec++;
            if (bus.hour !== e.h || bus.minute !== e.m || bus.second !== e.s ||
                bus.set_mode !== e.md || bus.blank_hour !== e.bh || bus.blank_min !== e.bm) begin
                n_bad++;
                $display("FAIL %s: got %0d:%0d:%0d mode=%0d bh=%0d bm=%0d, want %0d:%0d:%0d mode=%0d bh=%0d bm=%0d",
                         e.name, bus.hour, bus.minute, bus.second, bus.set_mode,
                         bus.blank_hour, bus.blank_min, e.h, e.m, e.s, e.md, e.bh, e.bm);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.tick_1hz   = 1'b0;
        bus.press_mode = 1'b0;
        bus.press_inc  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_N = 1'b1;
        expect_st("reset", 0, 0, 0, 0, 0, 0);

        repeat (61) cyc(1, 0, 0);
        expect_st("tick61", 0, 1, 1, 0, 0, 0);

        // Edit sequence, ticks issued alongside the presses must be ignored.
        cyc(0, 1, 0);
        expect_st("enter_hour", 0, 1, 1, 1, 0, 0);
        repeat (25) cyc(1, 0, 1);
        expect_st("hour_wrap", 1, 1, 1, 1, 0, 0);
        cyc(0, 1, 0);
        expect_st("enter_min", 1, 1, 1, 2, 0, 0);
        repeat (61) cyc(1, 0, 1);
        expect_st("min_wrap", 1, 2, 1, 2, 0, 0);
        cyc(0, 1, 0);
        expect_st("exit_run", 1, 2, 0, 0, 0, 0);

        // Preload 23:59:xx then roll over the full carry chain.
        cyc(0, 1, 0);
        repeat (22) cyc(0, 0, 1);
        cyc(0, 1, 0);
        repeat (57) cyc(0, 0, 1);
        cyc(0, 1, 0);
        expect_st("preload", 23, 59, 0, 0, 0, 0);
        repeat (59) cyc(1, 0, 0);
        expect_st("pre_roll", 23, 59, 59, 0, 0, 0);
        cyc(1, 0, 0);
        expect_st("rollover", 0, 0, 0, 0, 0, 0);

        cyc(0, 1, 0);
        cyc(0, 1, 1);
        expect_st("mode_wins", 0, 0, 0, 2, 0, 0);
        cyc(0, 1, 0);
        cyc(1, 1, 0);
        expect_st("tick_mode", 0, 0, 1, 1, 0, 0);

        // Just entered SET_HOUR; 39 blink toggles by cycle 9999 leaves it blank.
        idle(TIMEOUT - 1);
        expect_st("timeout_m1", 0, 0, 1, 1, 1, 0);
        idle(1);
        expect_st("timeout", 0, 0, 0, 0, 0, 0);

        cyc(0, 1, 0);
        idle(BLINK_HALF - 1);
        expect_st("blink_249", 0, 0, 0, 1, 0, 0);
        idle(1);
        expect_st("blink_250", 0, 0, 0, 1, 1, 0);
        idle(BLINK_HALF - 1);
        expect_st("blink_499", 0, 0, 0, 1, 1, 0);
        idle(1);
        expect_st("blink_500", 0, 0, 0, 1, 0, 0);

        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        idle(300);
        expect_st("blink_300", 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 1);
        expect_st("inc_unblank", 1, 0, 0, 1, 0, 0);
        idle(BLINK_HALF - 1);
        expect_st("restart_249", 1, 0, 0, 1, 0, 0);
        idle(1);
        expect_st("restart_250", 1, 0, 0, 1, 1, 0);

        cyc(0, 1, 0);
        expect_st("pre_rst", 1, 0, 0, 2, 0, 0);
        idle(1);
        rst_N = 1'b0;
        expect_st("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 rst_N = 1'b1;

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_bad += q.size();
            $display("FAIL drain: %0d checks never sampled, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
